// File: rtl/cache_line.sv
// Single cache line: WORDS x DATA_W data, tag, valid/dirty, en/ack request handshake with write-allocate.
// Define CACHE_LINE_PARITY_EN to store one even-parity bit per word and flag mismatches on read hits.
module cache_line #(
    parameter int DATA_W = 16,
    parameter int WORDS  = 4,
    parameter int TAG_W  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     write_i,
    input  logic                     inval_i,
    input  logic [TAG_W-1:0]         tagIn_i,
    input  logic [$clog2(WORDS)-1:0] wordSel_i,
    input  logic [DATA_W-1:0]        dataIn_i,
    output logic [DATA_W-1:0]        dataOut_o,
    output logic                     hit_o,
    output logic                     perr_o,
    output logic                     ack_o,
    output logic                     busy_o,
    output logic                     valid_o,
    output logic                     dirty_o,
    output logic [TAG_W-1:0]         tagOut_o
);
    localparam int SEL_W = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] words_q [WORDS];
    logic [TAG_W-1:0]  tag_q;
    logic              valid_q;
    logic              dirty_q;
    logic              reqWrite_q;
    logic [TAG_W-1:0]  reqTag_q;
    logic [SEL_W-1:0]  reqSel_q;
    logic [DATA_W-1:0] reqData_q;
    logic [DATA_W-1:0] dataOut_q;
    logic              hit_q;
    logic              perr_q;
    logic              lookupHit;
    logic              parityBad;

`ifdef CACHE_LINE_PARITY_EN
    logic [WORDS-1:0]  parity_q;
    assign parityBad = (^words_q[reqSel_q]) != parity_q[reqSel_q];
`else
    assign parityBad = 1'b0;
`endif

    assign lookupHit = valid_q && (tag_q == reqTag_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // inval has priority over en, so a simultaneous request never leaves IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en_i && !inval_i) state_d = LOOKUP;
            LOOKUP:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_o  = (state_q == RESP);
        busy_o = (state_q == LOOKUP) || (state_q == RESP);
    end

    // Request capture in IDLE, line update and response registers in LOOKUP
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < WORDS; i++) words_q[i] <= '0;
`ifdef CACHE_LINE_PARITY_EN
            parity_q   <= '0;
`endif
            tag_q      <= '0;
            valid_q    <= 1'b0;
            dirty_q    <= 1'b0;
            reqWrite_q <= 1'b0;
            reqTag_q   <= '0;
            reqSel_q   <= '0;
            reqData_q  <= '0;
            dataOut_q  <= '0;
            hit_q      <= 1'b0;
            perr_q     <= 1'b0;
        end else if (state_q == IDLE) begin
            if (inval_i) begin
                valid_q <= 1'b0;
                dirty_q <= 1'b0;
            end else if (en_i) begin
                reqWrite_q <= write_i;
                reqTag_q   <= tagIn_i;
                reqSel_q   <= wordSel_i;
                reqData_q  <= dataIn_i;
            end
        end else if (state_q == LOOKUP) begin
            perr_q <= 1'b0;
            if (reqWrite_q) begin
                dataOut_q <= reqData_q;
                dirty_q   <= 1'b1;
                hit_q     <= lookupHit;
                if (lookupHit) begin
                    words_q[reqSel_q] <= reqData_q;
`ifdef CACHE_LINE_PARITY_EN
                    parity_q[reqSel_q] <= ^reqData_q;
`endif
                end else begin
                    tag_q   <= reqTag_q;
                    valid_q <= 1'b1;
                    for (int i = 0; i < WORDS; i++) begin
                        words_q[i] <= (SEL_W'(i) == reqSel_q) ? reqData_q : '0;
`ifdef CACHE_LINE_PARITY_EN
                        parity_q[i] <= (SEL_W'(i) == reqSel_q) ? ^reqData_q : 1'b0;
`endif
                    end
                end
            end else if (lookupHit) begin
                dataOut_q <= words_q[reqSel_q];
                hit_q     <= !parityBad;
                perr_q    <= parityBad;
            end else begin
                dataOut_q <= '0;
                hit_q     <= 1'b0;
            end
        end
    end

    assign dataOut_o = dataOut_q;
    assign hit_o     = hit_q;
    assign perr_o    = perr_q;
    assign valid_o   = valid_q;
    assign dirty_o   = dirty_q;
    assign tagOut_o  = tag_q;

endmodule

// File: tb/tb_cache_line.sv
// Directed self-checking bench for cache_line: handshake latency, hit/miss, allocate, inval, reset abort.
// Parity-flip step is included only when CACHE_LINE_PARITY_EN is defined.
module tb_cache_line;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        write;
    logic        inval;
    logic [7:0]  tagIn;
    logic [1:0]  wordSel;
    logic [15:0] dataIn;
    logic [15:0] dataOut;
    logic        hit;
    logic        perr;
    logic        ack;
    logic        busy;
    logic        valid;
    logic        dirty;
    logic [7:0]  tagOut;

    int passCount  = 0;
    int checkCount = 0;
    int ackSeen;

    cache_line #(.DATA_W(16), .WORDS(4), .TAG_W(8)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .write_i   (write),
        .inval_i   (inval),
        .tagIn_i   (tagIn),
        .wordSel_i (wordSel),
        .dataIn_i  (dataIn),
        .dataOut_o (dataOut),
        .hit_o     (hit),
        .perr_o    (perr),
        .ack_o     (ack),
        .busy_o    (busy),
        .valid_o   (valid),
        .dirty_o   (dirty),
        .tagOut_o  (tagOut)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
    endtask

    // Issues one request and returns sampling at the negedge where ack is expected
    task automatic applyStimulus(input logic w, input logic [7:0] t, input logic [1:0] s, input logic [15:0] d);
        int n;
        @(negedge clk);
        en = 1'b1; write = w; tagIn = t; wordSel = s; dataIn = d;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        checkOutput("lookup_ack_low", {31'b0, ack}, 32'd0);
        n = 0;
        while (!ack && n < 4) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ack_latency", n, 32'd1);
    endtask

    task automatic countAcks(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (ack) n++;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; write = 1'b0; inval = 1'b0;
        tagIn = '0; wordSel = '0; dataIn = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_ack", {31'b0, ack}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_valid", {31'b0, valid}, 32'd0);
        checkOutput("rst_dirty", {31'b0, dirty}, 32'd0);
        checkOutput("rst_tag", {24'b0, tagOut}, 32'd0);
        checkOutput("rst_data", {16'b0, dataOut}, 32'd0);
        checkOutput("rst_hit", {31'b0, hit}, 32'd0);
        checkOutput("rst_perr", {31'b0, perr}, 32'd0);

        $display("[TB] read on empty line");
        applyStimulus(1'b0, 8'h12, 2'd1, 16'h0000);
        checkOutput("cold_hit", {31'b0, hit}, 32'd0);
        checkOutput("cold_data", {16'b0, dataOut}, 32'd0);
        checkOutput("cold_valid", {31'b0, valid}, 32'd0);
        checkOutput("cold_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("ack_pulse_end", {31'b0, ack}, 32'd0);
        checkOutput("busy_end", {31'b0, busy}, 32'd0);

        $display("[TB] write miss allocates, then read hit");
        applyStimulus(1'b1, 8'h12, 2'd2, 16'hBEEF);
        checkOutput("alloc_hit", {31'b0, hit}, 32'd0);
        checkOutput("alloc_data", {16'b0, dataOut}, 32'h0000BEEF);
        checkOutput("alloc_valid", {31'b0, valid}, 32'd1);
        checkOutput("alloc_dirty", {31'b0, dirty}, 32'd1);
        checkOutput("alloc_tag", {24'b0, tagOut}, 32'h12);
        applyStimulus(1'b0, 8'h12, 2'd2, 16'h0000);
        checkOutput("rd2_hit", {31'b0, hit}, 32'd1);
        checkOutput("rd2_data", {16'b0, dataOut}, 32'h0000BEEF);
        checkOutput("rd2_perr", {31'b0, perr}, 32'd0);

        $display("[TB] cleared word, tag mismatch, write hit, top word");
        applyStimulus(1'b0, 8'h12, 2'd0, 16'h0000);
        checkOutput("rd0_hit", {31'b0, hit}, 32'd1);
        checkOutput("rd0_data", {16'b0, dataOut}, 32'd0);
        applyStimulus(1'b0, 8'h34, 2'd2, 16'h0000);
        checkOutput("tagmiss_hit", {31'b0, hit}, 32'd0);
        checkOutput("tagmiss_data", {16'b0, dataOut}, 32'd0);
        checkOutput("tagmiss_tag", {24'b0, tagOut}, 32'h12);
        applyStimulus(1'b1, 8'h12, 2'd3, 16'h5678);
        checkOutput("wrhit_hit", {31'b0, hit}, 32'd1);
        checkOutput("wrhit_data", {16'b0, dataOut}, 32'h00005678);
        applyStimulus(1'b0, 8'h12, 2'd3, 16'h0000);
        checkOutput("rd3_data", {16'b0, dataOut}, 32'h00005678);
        applyStimulus(1'b0, 8'h12, 2'd2, 16'h0000);
        checkOutput("rd2_kept", {16'b0, dataOut}, 32'h0000BEEF);

        $display("[TB] en while busy is dropped");
        @(negedge clk);
        en = 1'b1; write = 1'b0; tagIn = 8'h12; wordSel = 2'd2;
        @(posedge clk);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        checkOutput("busy_en_ack", {31'b0, ack}, 32'd1);
        countAcks(6, ackSeen);
        checkOutput("busy_en_dropped", ackSeen, 32'd0);

        $display("[TB] inval beats en");
        @(negedge clk);
        inval = 1'b1; en = 1'b1;
        @(negedge clk);
        inval = 1'b0; en = 1'b0;
        checkOutput("inval_valid", {31'b0, valid}, 32'd0);
        checkOutput("inval_dirty", {31'b0, dirty}, 32'd0);
        checkOutput("inval_tag", {24'b0, tagOut}, 32'h12);
        checkOutput("inval_busy", {31'b0, busy}, 32'd0);
        countAcks(4, ackSeen);
        checkOutput("inval_no_ack", ackSeen, 32'd0);
        applyStimulus(1'b0, 8'h12, 2'd2, 16'h0000);
        checkOutput("after_inval_hit", {31'b0, hit}, 32'd0);
        checkOutput("after_inval_data", {16'b0, dataOut}, 32'd0);

        $display("[TB] reset during write lookup");
        applyStimulus(1'b1, 8'h12, 2'd0, 16'h1111);
        checkOutput("pre_rst_valid", {31'b0, valid}, 32'd1);
        @(negedge clk);
        en = 1'b1; write = 1'b1; tagIn = 8'h12; wordSel = 2'd0; dataIn = 16'hAAAA;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_ack", {31'b0, ack}, 32'd0);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_valid", {31'b0, valid}, 32'd0);
        checkOutput("abort_data", {16'b0, dataOut}, 32'd0);
        countAcks(4, ackSeen);
        checkOutput("abort_no_ack", ackSeen, 32'd0);
        applyStimulus(1'b0, 8'h12, 2'd0, 16'h0000);
        checkOutput("post_abort_hit", {31'b0, hit}, 32'd0);
        checkOutput("post_abort_data", {16'b0, dataOut}, 32'd0);

`ifdef CACHE_LINE_PARITY_EN
        $display("[TB] corrupted parity bit");
        begin
            logic [3:0] parSnap;
            applyStimulus(1'b1, 8'h12, 2'd0, 16'h0001);
            @(negedge clk);
            parSnap = dut.parity_q;
            force dut.parity_q = parSnap ^ 4'b0001;
            applyStimulus(1'b0, 8'h12, 2'd0, 16'h0000);
            checkOutput("par_perr", {31'b0, perr}, 32'd1);
            checkOutput("par_hit", {31'b0, hit}, 32'd0);
            checkOutput("par_data", {16'b0, dataOut}, 32'h00000001);
            release dut.parity_q;
        end
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
